// File: rtl/gates_checker.sv
// Self-checking harness for a ten-output two-input gate block: compares observed
// outputs against the x/y truth table, tracks input coverage, and records the first failure.
module gates_checker #(
  parameter int TIMEOUT = 64,
  parameter int ERR_W   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_valid,
  input  logic             i_x,
  input  logic             i_y,
  input  logic [9:0]       i_obs,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic             o_timeout,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic [3:0]       o_cov,
  output logic             o_fail_seen,
  output logic [1:0]       o_fail_vec,
  output logic [9:0]       o_fail_mask
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_RUN     = 2'd1;
  localparam logic [1:0]  S_DONE    = 2'd2;
  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [15:0]      r_idle_cnt;
  logic [ERR_W-1:0] r_err_cnt;
  logic [3:0]       r_cov;
  logic             r_timeout;
  logic             r_fail_seen;
  logic [1:0]       r_fail_vec;
  logic [9:0]       r_fail_mask;

  logic       w_accept;
  logic [1:0] w_vec;
  logic [9:0] w_expected;
  logic [9:0] w_diff;
  logic [3:0] w_cov_next;

  // Expected row in i_obs bit order: zero, one, ~y, ~x, xnor, xor, nor, or, nand, and.
  assign w_vec      = {i_x, i_y};
  assign w_expected = {1'b0, 1'b1, ~i_y, ~i_x, ~(i_x ^ i_y), i_x ^ i_y,
                       ~(i_x | i_y), i_x | i_y, ~(i_x & i_y), i_x & i_y};
  assign w_diff     = w_expected ^ i_obs;
  assign w_cov_next = r_cov | (4'b0001 << w_vec);

  assign o_ready  = (r_state == S_RUN) & ~i_start;
  assign w_accept = o_ready & i_valid;

  // A start pulse always wins and clears the run; acceptance beats the timeout threshold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_idle_cnt  <= '0;
      r_err_cnt   <= '0;
      r_cov       <= '0;
      r_timeout   <= 1'b0;
      r_fail_seen <= 1'b0;
      r_fail_vec  <= '0;
      r_fail_mask <= '0;
    end else if (i_start) begin
      r_state     <= S_RUN;
      r_idle_cnt  <= '0;
      r_err_cnt   <= '0;
      r_cov       <= '0;
      r_timeout   <= 1'b0;
      r_fail_seen <= 1'b0;
      r_fail_vec  <= '0;
      r_fail_mask <= '0;
    end else if (r_state == S_RUN) begin
      if (w_accept) begin
        r_idle_cnt <= '0;
        r_cov      <= w_cov_next;
        if (w_diff != 10'd0) begin
          if (r_err_cnt != {ERR_W{1'b1}}) begin
            r_err_cnt <= r_err_cnt + 1'b1;
          end
          if (!r_fail_seen) begin
            r_fail_seen <= 1'b1;
            r_fail_vec  <= w_vec;
            r_fail_mask <= w_diff;
          end
        end
        if (w_cov_next == 4'hF) begin
          r_state <= S_DONE;
        end
      end else if (r_idle_cnt == IDLE_LAST) begin
        r_state   <= S_DONE;
        r_timeout <= 1'b1;
      end else begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end
    end
  end

  assign o_busy      = (r_state == S_RUN);
  assign o_done      = (r_state == S_DONE);
  assign o_timeout   = r_timeout;
  assign o_err_cnt   = r_err_cnt;
  assign o_cov       = r_cov;
  assign o_fail_seen = r_fail_seen;
  assign o_fail_vec  = r_fail_vec;
  assign o_fail_mask = r_fail_mask;
  assign o_pass      = o_done & (r_err_cnt == '0) & (r_cov == 4'hF) & ~r_timeout;

endmodule
